// File: rtl/arb_pkg.sv
// Shared types and the rotating first-set-bit search for the round-robin arbiter.
package arb_pkg;

  localparam int ARB_MAX_N = 16;
  localparam int ARB_IDX_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [ARB_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req scanning start, start+1, ..., start+n-1 (all mod n).
  // start must be below n; bits of req at or above n are ignored.
  function automatic pick_t rr_first(input logic [ARB_MAX_N-1:0] req,
                                     input int unsigned          start,
                                     input int unsigned          n);
    pick_t       r;
    int unsigned pos;
    r = '0;
    for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
      pos = start + i;
      if (pos >= n) pos = pos - n;
      if (!r.found && (i < n) && (pos < ARB_MAX_N) && req[pos[ARB_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = pos[ARB_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first requester from start_i, skipping excl_i.
module rr_pick
  import arb_pkg::*;
#(
  parameter int   N   = 4,
  localparam int  IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] start_i,
  input  logic [N-1:0]   excl_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);

  pick_t res;

  assign res     = rr_first(ARB_MAX_N'(req_i & ~excl_i), 32'(start_i), N);
  assign found_o = res.found;
  assign idx_o   = IDW'(res.idx);

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with registered grants, grant locking and bounded hold.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int  N        = 4,
  parameter int  MAX_HOLD = 4,
  localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           preempt
);

  localparam int            HW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;
  // With unlimited hold the counter only needs to record "held at least once".
  localparam logic [HW-1:0] HOLD_SAT = HW'((MAX_HOLD == 0) ? 1 : MAX_HOLD);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           preempt_q, preempt_d;

  logic [IDW-1:0] pick_start;
  logic [N-1:0]   pick_excl;
  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic           grant_new;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    return (i == IDW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  // Idle searches from the rotating pointer; a busy owner is skipped and search starts just after it.
  always_comb begin
    pick_start = ptr_q;
    pick_excl  = '0;
    if (state_q == BUSY) begin
      pick_start = next_idx(gnt_id_q);
      pick_excl  = N'(1) << gnt_id_q;
    end
  end

  rr_pick #(.N(N)) u_pick (
    .req_i   (req),
    .start_i (pick_start),
    .excl_i  (pick_excl),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Next-state decision: new grant, hand-off on release, preemption after the hold limit, or keep.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    preempt_d = 1'b0;
    grant_new = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) grant_new = 1'b1;
      end
      BUSY: begin
        if (!req[gnt_id_q]) begin
          if (pick_found) begin
            grant_new = 1'b1;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
          end
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_SAT) && pick_found) begin
          grant_new = 1'b1;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (grant_new) begin
      state_d  = BUSY;
      gnt_d    = N'(1) << pick_idx;
      gnt_id_d = pick_idx;
      hold_d   = HW'(1);
      ptr_d    = next_idx(pick_idx);
    end
    gnt_valid_d = |gnt_d;
  end

  // State and registered outputs; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      preempt_q   <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign preempt   = preempt_q;

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- N-requester round-robin arbiter with grant locking and a bounded hold time.
- Shares a single resource (bus or memory port) among requesters. It generalises the 2-way req/gnt arbiter, so existing mutual-exclusion and req-before-gnt assertions still apply per requester.
- Grants are registered: a grant is always caused by a request sampled in the previous cycle.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 4, maximum consecutive cycles an owner keeps the grant while others wait; 0 = unlimited (no preemption).
- IDW, $clog2(N), width of gnt_id (derived, not overridden).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N  per-requester request level; held high while the resource is wanted.
- gnt  out  N  one-hot-or-zero registered grant vector.
- gnt_valid  out  1  OR of gnt, registered.
- gnt_id  out  IDW  index of current owner; 0 when gnt_valid=0.
- preempt  out  1  one-cycle pulse in the first cycle of a grant obtained by preempting an owner still requesting.

Behaviour:
- Reset (reset=0, async): gnt=0, gnt_valid=0, gnt_id=0, preempt=0, state=IDLE, ptr=0, hold_cnt=0. Outputs clear immediately without waiting for clk. First decision is made on the first posedge after reset deasserts.
- ptr: rotating priority start. Search order is ptr, ptr+1, …, ptr+N-1 mod N. After any grant to k, ptr=(k+1) mod N.
- States: IDLE (no owner), BUSY (owner k = gnt_id).
- IDLE, req==0: stay IDLE, gnt=0.
- IDLE, req!=0: pick first set bit from ptr. Next cycle: gnt=onehot(j), state=BUSY, hold_cnt=1.
- BUSY, req[k]=0 (release): pick first set bit from (k+1) mod N, excluding k.
  - If found j: gnt=onehot(j) next cycle, with no idle bubble; hold_cnt=1; preempt=0.
  - If none: next cycle gnt=0, IDLE.
- BUSY, req[k]=1, and (MAX_HOLD==0 or hold_cnt<MAX_HOLD or no other req bit set): keep k. hold_cnt increments, saturating at MAX_HOLD.
- BUSY, req[k]=1, MAX_HOLD!=0, hold_cnt==MAX_HOLD, another req bit set: preempt.
  - Grant the first other requester from (k+1) mod N.
  - Next cycle: preempt=1, hold_cnt=1.
  - The previous owner is re-queued through normal rotation only.
- Latency: request to grant is 1 cycle when the resource is free. Release to grant removal is 1 cycle.
- Invariants:
  - $onehot0(gnt).
  - gnt[i] implies $past(req[i]).
  - gnt_id==index of gnt when gnt_valid.
  - Fairness: with all N requesting continuously, every requester is granted within N*MAX_HOLD cycles.
- Simultaneous release and new request of the same index: treated as a drop. Other requesters have priority via rotation. If it is the only requester it is regranted next cycle as a fresh grant.
- Width rules: hold_cnt width $clog2(MAX_HOLD+1), minimum 1. All index arithmetic is mod N (N need not be a power of 2).

Decomposition:
- Package arb_pkg:
  - arb_state_e {IDLE, BUSY}.
  - Function rr_first(req, start, N) returning found flag and index.
  - Constant ARB_MAX_N=16.
- Sub-module rr_pick (combinational): inputs req, start index, exclude mask; outputs found and idx. Instantiated once in rr_arbiter; unit-testable separately.

Test Plan:
- Hold reset=0 with req=4'b1111 for 5 cycles -> gnt=0, gnt_valid=0 throughout. Release reset -> gnt=4'b0001, gnt_id=0 one cycle after the first posedge.
- req=4'b0100 held 10 cycles, MAX_HOLD=4 -> gnt=4'b0100 for all cycles from cycle 1, preempt never asserted. Drop req -> gnt=0 next cycle.
- req=4'b1111 held 20 cycles, MAX_HOLD=4 -> owners 0,1,2,3,0 with 4 cycles each. preempt pulses at each switch; gnt is never zero after the first grant.
- Owner 1, req goes 4'b1011 to 4'b1001 at cycle t -> gnt=4'b1000 (id 3) at t+1, preempt=0, no gap.
- ptr=2 (after owner 1 releases to idle), then req=4'b0011 -> gnt=4'b0001, since search order is 2,3,0. ptr becomes 1.
- Assert reset mid-cycle while gnt=4'b0010 -> gnt=0 before the next posedge. After release with req=4'b0010 -> gnt=4'b0010, since ptr reset to 0 and search runs 0 then 1.
